panda_risc_v_reg_file_rd_arbiter: RTL and testbench
===================================================

PANDA_RISC_V_REG_FILE_RD_ARBITER -- requirements
Module: panda_risc_v_reg_file_rd_arbiter

Interface
REQ-001 Parameter STARVE_TH, default 4, means the number of consecutive denied s0 request cycles that triggers priority boost; legal range 1..15.
REQ-002 Parameter simulation_delay, default 1, means the simulation delay on register updates.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port resetn, input, 1 bit: reset is synchronous and active-low.
REQ-005 Port s0_req, input, 1 bit: read request from the IFU JALR base-address reader.
REQ-006 Port s0_addr, input, 5 bits: s0 register index.
REQ-007 Port s0_grant, output, 1 bit: s0 read granted this cycle.
REQ-008 Port s0_dout, output, 32 bits: s0 read data.
REQ-009 Port s0_dout_vld, output, 1 bit: s0_dout is valid this cycle.
REQ-010 Ports s1_req, s1_addr, s1_grant, s1_dout and s1_dout_vld have the same directions and widths as the s0 set and serve the dispatch unit.
REQ-011 Port m_rd_en, output, 1 bit: shared register-file read port enable.
REQ-012 Port m_rd_addr, output, 5 bits: shared read port address.
REQ-013 Port m_rd_dout, input, 32 bits: register-file data, valid exactly 1 cycle after m_rd_en.
REQ-014 Port starve_boost, output, 1 bit: s0 currently holds boosted priority.

Function
REQ-015 Grant SHALL be combinational from the current-cycle req/addr and the registered state; a request is held high until granted.
REQ-016 A request with addr == 0 (x0) SHALL be granted in the same cycle and SHALL NOT use the shared port.
REQ-017 Both requesters MAY be granted in the same cycle if at least one addresses x0.
REQ-018 For contention (both requesting, both addr != 0), s1 SHALL win when starve_boost = 0 and s0 SHALL win when starve_boost = 1.
REQ-019 m_rd_en SHALL be 1 iff a non-x0 grant occurs; m_rd_addr SHALL equal the winner's addr, and 0 when m_rd_en = 0.
REQ-020 Latency: a grant in cycle N SHALL give sX_dout_vld = 1 in cycle N+1 for exactly one cycle, with sX_dout = m_rd_dout, or 32'h0 for x0.
REQ-021 sX_dout SHALL hold its last returned value while sX_dout_vld = 0.
REQ-022 Starvation counter (4 bits):
- increments when s0_req = 1 and s0_grant = 0;
- clears to 0 when s0_grant = 1 or s0_req = 0;
- saturates at STARVE_TH.
REQ-023 starve_boost SHALL be 1 iff counter == STARVE_TH, so the boost takes effect in the cycle after the threshold-reaching edge.
REQ-024 A boosted s0 grant SHALL clear the counter and drop starve_boost in the next cycle; s1 then regains priority.
REQ-025 s1 alone requesting SHALL be granted regardless of starve_boost; s0 alone requesting SHALL be granted at once.

Reset
REQ-026 While resetn = 0 at a clock edge: counter = 0, starve_boost = 0, s0_dout_vld = s1_dout_vld = 0, s0_dout = s1_dout = 32'h0.
REQ-027 While resetn = 0: s0_grant = s1_grant = 0, m_rd_en = 0, m_rd_addr = 0.
REQ-028 A grant in the cycle before reset asserts SHALL NOT produce a dout_vld pulse during reset.

Verification
REQ-029 Single s0, no contention: s0_req = 1, addr = 5, m_rd_dout = 32'h1234 the next cycle -> s0_grant = 1 and m_rd_addr = 5 in cycle N; s0_dout_vld = 1 with s0_dout = 32'h1234 in cycle N+1.
REQ-030 x0 sharing: s0 addr = 0 and s1 addr = 7, both requesting -> both granted; m_rd_addr = 7; s0_dout = 0 and s1_dout = m_rd_dout in N+1.
REQ-031 Starvation with STARVE_TH = 4, both requesting continuously with non-x0 addresses:
- s1 is granted for cycles 0-3;
- starve_boost = 1 in cycle 4 and s0 is granted in cycle 4;
- starve_boost = 0 in cycle 5 and s1 is granted in cycle 5.
REQ-032 Counter clear: s0 denied for 3 cycles, then s0_req drops for 1 cycle, then contention resumes -> the counter restarts from 0 and no boost occurs before 4 further denials.
REQ-033 Reset mid-operation: resetn = 0 in the cycle after a grant -> no dout_vld pulse; all outputs at reset values; normal arbitration resumes on the first cycle with resetn = 1.
REQ-034 Random stress: all of the following SHALL hold in every cycle:
- never two non-x0 grants in the same cycle;
- every grant is followed by exactly one dout_vld pulse;
- no s0 wait exceeds STARVE_TH + 1 cycles.

Source files
------------

// File: rtl/panda_risc_v_reg_file_rd_arbiter.sv
// Shares one register-file read port between the IFU JALR reader (s0) and the dispatch unit (s1).
// x0 reads bypass the port; s1 has priority unless s0 has been starved for STARVE_TH cycles.
module panda_risc_v_reg_file_rd_arbiter #(
  parameter int STARVE_TH        = 4,
  parameter int simulation_delay = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_req,
  input  logic [4:0]  s0_addr,
  output logic        s0_grant,
  output logic [31:0] s0_dout,
  output logic        s0_dout_vld,
  input  logic        s1_req,
  input  logic [4:0]  s1_addr,
  output logic        s1_grant,
  output logic [31:0] s1_dout,
  output logic        s1_dout_vld,
  output logic        m_rd_en,
  output logic [4:0]  m_rd_addr,
  input  logic [31:0] m_rd_dout,
  output logic        starve_boost
);

  if (STARVE_TH < 1 || STARVE_TH > 15 || simulation_delay < 0) begin : g_bad_param
    $error("panda_risc_v_reg_file_rd_arbiter: STARVE_TH must be 1..15");
  end

  localparam logic [3:0] starve_th_c = 4'(STARVE_TH);

  logic        s0_nz_req, s1_nz_req, contention, boost;
  logic        s0_port_grant, s1_port_grant;
  logic [3:0]  starve_cnt;
  logic        s0_vld_q, s1_vld_q, s0_port_q, s1_port_q;
  logic [31:0] s0_hold_q, s1_hold_q;
  logic [31:0] s0_rdata, s1_rdata;

  assign s0_nz_req  = s0_req && (s0_addr != 5'd0);
  assign s1_nz_req  = s1_req && (s1_addr != 5'd0);
  assign contention = s0_nz_req && s1_nz_req;
  assign boost      = (starve_cnt == starve_th_c);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s0_grant  = 1'b0;
    s1_grant  = 1'b0;
    m_rd_en   = 1'b0;
    m_rd_addr = 5'd0;
    if (resetn) begin
      s0_grant = s0_req && (!contention || boost);
      s1_grant = s1_req && (!contention || !boost);
      if (s0_grant && s0_nz_req) begin
        m_rd_en   = 1'b1;
        m_rd_addr = s0_addr;
      end else if (s1_grant && s1_nz_req) begin
        m_rd_en   = 1'b1;
        m_rd_addr = s1_addr;
      end
    end
  end

  assign s0_port_grant = s0_grant && s0_nz_req;
  assign s1_port_grant = s1_grant && s1_nz_req;

  // Read data arrives one cycle after the grant; x0 always reads as zero.
  assign s0_rdata = s0_port_q ? m_rd_dout : 32'h0;
  assign s1_rdata = s1_port_q ? m_rd_dout : 32'h0;

  // Gating with resetn keeps a grant from the cycle before reset from pulsing valid.
  assign s0_dout_vld  = resetn && s0_vld_q;
  assign s1_dout_vld  = resetn && s1_vld_q;
  assign s0_dout      = !resetn ? 32'h0 : (s0_vld_q ? s0_rdata : s0_hold_q);
  assign s1_dout      = !resetn ? 32'h0 : (s1_vld_q ? s1_rdata : s1_hold_q);
  assign starve_boost = resetn && boost;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= 4'd0;
      s0_vld_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s0_port_q  <= 1'b0;
      s1_port_q  <= 1'b0;
      s0_hold_q  <= 32'h0;
      s1_hold_q  <= 32'h0;
    end else begin
      s0_vld_q  <= s0_grant;
      s1_vld_q  <= s1_grant;
      s0_port_q <= s0_port_grant;
      s1_port_q <= s1_port_grant;
      if (s0_vld_q) s0_hold_q <= s0_rdata;
      if (s1_vld_q) s1_hold_q <= s1_rdata;
      if (s0_req && !s0_grant)
        starve_cnt <= boost ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_panda_risc_v_reg_file_rd_arbiter.sv
// Scoreboard bench for the register-file read arbiter: a behavioural model predicts grants,
// port use and boost each cycle, and queues the expected read-back for the following cycle.
module tb_panda_risc_v_reg_file_rd_arbiter;

  localparam int TH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s0_req, s1_req;
  logic [4:0]  s0_addr, s1_addr;
  logic        s0_grant, s1_grant, s0_dout_vld, s1_dout_vld;
  logic [31:0] s0_dout, s1_dout, m_rd_dout;
  logic        m_rd_en, starve_boost;
  logic [4:0]  m_rd_addr;

  panda_risc_v_reg_file_rd_arbiter #(.STARVE_TH(TH), .simulation_delay(1)) dut (
    .clk(clk), .resetn(resetn),
    .s0_req(s0_req), .s0_addr(s0_addr), .s0_grant(s0_grant),
    .s0_dout(s0_dout), .s0_dout_vld(s0_dout_vld),
    .s1_req(s1_req), .s1_addr(s1_addr), .s1_grant(s1_grant),
    .s1_dout(s1_dout), .s1_dout_vld(s1_dout_vld),
    .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_dout(m_rd_dout),
    .starve_boost(starve_boost)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries: 1 = read went through the shared port, 0 = x0 read.
  bit          q0[$], q1[$];
  logic [31:0] hold0 = 32'h0, hold1 = 32'h0;
  int          m_cnt = 0;
  int          s0_wait = 0;
  bit          g0, g1;

  task automatic check_rdata(input string tag, input bit rst_ok, inout bit q[$],
                             inout logic [31:0] hold, input logic got_vld, input logic [31:0] got);
    bit          has, is_port;
    logic [31:0] exp;
    has = (q.size() > 0);
    is_port = 1'b0;
    if (has) is_port = q.pop_front();
    if (!rst_ok) begin
      hold = 32'h0;
      check({tag, "_vld"}, {31'h0, got_vld}, 32'h0);
      check({tag, "_dout"}, got, 32'h0);
    end else if (has) begin
      exp = is_port ? m_rd_dout : 32'h0;
      hold = exp;
      check({tag, "_vld"}, {31'h0, got_vld}, 32'h1);
      check({tag, "_dout"}, got, exp);
    end else begin
      check({tag, "_vld"}, {31'h0, got_vld}, 32'h0);
      check({tag, "_hold"}, got, hold);
    end
  endtask

  // One clock cycle: drive, predict, compare, then advance. Entered 1 time unit after posedge.
  task automatic cycle(input bit r0, input logic [4:0] a0, input bit r1, input logic [4:0] a1,
                       input bit rst);
    bit         boost_m, clash;
    logic [4:0] exp_addr;
    resetn    = rst;
    s0_req    = r0;  s0_addr = a0;
    s1_req    = r1;  s1_addr = a1;
    m_rd_dout = $urandom;
    #2;
    check_rdata("s0", rst, q0, hold0, s0_dout_vld, s0_dout);
    check_rdata("s1", rst, q1, hold1, s1_dout_vld, s1_dout);

    boost_m = rst && (m_cnt == TH);
    clash   = r0 && r1 && (a0 != 0) && (a1 != 0);
    if (!rst)       begin g0 = 0; g1 = 0; end
    else if (clash) begin g0 = boost_m; g1 = !boost_m; end
    else            begin g0 = r0; g1 = r1; end

    if (g0 && a0 != 0)      exp_addr = a0;
    else if (g1 && a1 != 0) exp_addr = a1;
    else                    exp_addr = 5'd0;

    check("s0_grant", {31'h0, s0_grant}, {31'h0, g0});
    check("s1_grant", {31'h0, s1_grant}, {31'h0, g1});
    check("starve_boost", {31'h0, starve_boost}, {31'h0, boost_m});
    check("m_rd_en", {31'h0, m_rd_en}, {31'h0, exp_addr != 5'd0});
    check("m_rd_addr", {27'h0, m_rd_addr}, {27'h0, exp_addr});
    check("two_port_grants", {31'h0, (s0_grant && s0_addr != 0) && (s1_grant && s1_addr != 0)}, 32'h0);

    if (g0) q0.push_back(a0 != 0);
    if (g1) q1.push_back(a1 != 0);

    if (rst && r0) s0_wait++;
    if (g0) begin
      check("s0_wait_bound", {31'h0, s0_wait <= TH + 1}, 32'h1);
      s0_wait = 0;
    end else if (!rst || !r0) s0_wait = 0;

    if (!rst)           m_cnt = 0;
    else if (r0 && !g0) m_cnt = (m_cnt < TH) ? m_cnt + 1 : TH;
    else                m_cnt = 0;

    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         r0, r1;
    logic [4:0] a0, a1;
    resetn = 1'b0;
    s0_req = 1'b0; s1_req = 1'b0; s0_addr = '0; s1_addr = '0; m_rd_dout = '0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 3, 1, 4, 0);          // requests during reset are ignored
    cycle(0, 0, 0, 0, 1);

    cycle(1, 5, 0, 0, 1);          // single s0 read
    cycle(0, 0, 0, 0, 1);          // read-back cycle
    cycle(0, 0, 0, 0, 1);          // hold value

    cycle(1, 0, 1, 7, 1);          // x0 shares with a port read
    cycle(0, 0, 0, 0, 1);

    for (int i = 0; i < 7; i++)    // starvation boost and release
      cycle(1, 9, 1, 5'(10 + i), 1);
    cycle(0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) cycle(1, 12, 1, 13, 1);
    cycle(0, 0, 1, 14, 1);         // s0 drops: counter clears
    for (int i = 0; i < 6; i++) cycle(1, 15, 1, 16, 1);
    cycle(0, 0, 0, 0, 1);

    cycle(1, 5, 0, 0, 1);          // grant right before reset
    cycle(0, 0, 0, 0, 0);
    cycle(1, 9, 1, 3, 1);          // arbitration resumes at once
    cycle(0, 0, 0, 0, 1);

    cycle(1, 0, 0, 0, 1);          // s0 alone, x0
    cycle(0, 0, 1, 0, 1);          // s1 alone, x0
    cycle(0, 0, 0, 0, 1);

    r0 = 0; r1 = 0; a0 = '0; a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!r0 && $urandom_range(0, 3) != 0) begin
        r0 = 1;
        a0 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      if (!r1 && $urandom_range(0, 4) != 0) begin
        r1 = 1;
        a1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      cycle(r0, a0, r1, a1, 1);
      if (g0) r0 = 0;
      if (g1) r1 = 0;
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
